// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32-subset decode stage with valid/ready handshakes,
//            load-use interlock and flush. Macro DECODE_SKID_EN adds a
//            1-entry skid register behind the output register.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter int OP_W = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [PC_W-1:0] in_pc,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [OP_W-1:0] op,
    output logic            y_sel,
    output logic            write,
    output logic [4:0]      addr_a,
    output logic [4:0]      addr_b,
    output logic [4:0]      addr_d,
    output logic [XLEN-1:0] immed,
    output logic            read_mmu,
    output logic            write_mmu,
    output logic            byte_sel_mmu,
    output logic            illegal
);

    localparam logic [6:0] c_OPC_R    = 7'b0110011;
    localparam logic [6:0] c_OPC_LOAD = 7'b0000011;
    localparam logic [6:0] c_OPC_ALUI = 7'b0010011;
    localparam logic [6:0] c_OPC_S    = 7'b0100011;
    localparam logic [6:0] c_OPC_B    = 7'b1100011;
    localparam logic [6:0] c_OPC_J    = 7'b1101111;
    localparam int         c_BW       = PC_W + OP_W + 2 + 15 + XLEN + 4;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    logic       w_rd_nz;

    assign w_opcode = in_ir[6:0];
    assign w_rd     = in_ir[11:7];
    assign w_funct3 = in_ir[14:12];
    assign w_rs1    = in_ir[19:15];
    assign w_rs2    = in_ir[24:20];
    assign w_funct7 = in_ir[31:25];
    assign w_rd_nz  = (w_rd != 5'd0);

    // Raw immediates held as signed so the XLEN casts below sign-extend.
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [20:0] w_imm_j;

    assign w_imm_i = in_ir[31:20];
    assign w_imm_s = {in_ir[31:25], in_ir[11:7]};
    assign w_imm_b = {in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
    assign w_imm_j = {in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};

    logic [OP_W-1:0] w_op;
    logic            w_y_sel;
    logic            w_write;
    logic            w_read_mmu;
    logic            w_write_mmu;
    logic            w_byte_sel;
    logic            w_illegal;
    logic [XLEN-1:0] w_immed;

    always_comb begin
        w_op        = {4'b0000, w_opcode, w_funct3};
        w_y_sel     = 1'b0;
        w_write     = 1'b0;
        w_read_mmu  = 1'b0;
        w_write_mmu = 1'b0;
        w_byte_sel  = 1'b0;
        w_illegal   = 1'b1;
        w_immed     = '0;
        case (w_opcode)
            c_OPC_R: begin
                w_op = {w_opcode, w_funct7};
                if (w_funct3 == 3'b000 &&
                    (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000 ||
                     w_funct7 == 7'b0000001)) begin
                    w_illegal = 1'b0;
                    w_y_sel   = 1'b1;
                    w_write   = w_rd_nz;
                end
            end
            c_OPC_LOAD: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b010) begin
                    w_illegal  = 1'b0;
                    w_immed    = XLEN'(w_imm_i);
                    w_read_mmu = 1'b1;
                    w_byte_sel = (w_funct3 == 3'b000);
                    w_write    = w_rd_nz;
                end
            end
            c_OPC_ALUI: begin
                if (w_funct3 == 3'b000) begin
                    w_illegal = 1'b0;
                    w_immed   = XLEN'(w_imm_i);
                    w_write   = w_rd_nz;
                end
            end
            c_OPC_S: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b010) begin
                    w_illegal   = 1'b0;
                    w_immed     = XLEN'(w_imm_s);
                    w_write_mmu = 1'b1;
                    w_byte_sel  = (w_funct3 == 3'b000);
                end
            end
            c_OPC_B: begin
                if (w_funct3 == 3'b000) begin
                    w_illegal = 1'b0;
                    w_immed   = XLEN'(w_imm_b);
                    w_y_sel   = 1'b1;
                end
            end
            c_OPC_J: begin
                w_illegal = 1'b0;
                w_immed   = XLEN'(w_imm_j);
                w_write   = w_rd_nz;
            end
            default: begin
            end
        endcase
    end

    // Operand usage is keyed on opcode alone so the interlock stays conservative
    // for malformed encodings of a known format.
    logic w_rs1_used;
    logic w_rs2_used;
    logic w_hazard;
    logic w_accept;

    assign w_rs1_used = (w_opcode != c_OPC_J);
    assign w_rs2_used = (w_opcode == c_OPC_R) || (w_opcode == c_OPC_S) ||
                        (w_opcode == c_OPC_B);
    assign w_hazard   = in_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                        ((w_rs1_used && (w_rs1 == ex_load_rd)) ||
                         (w_rs2_used && (w_rs2 == ex_load_rd)));
    assign w_accept   = in_valid && in_ready;

    logic [c_BW-1:0] w_bundle;
    logic [c_BW-1:0] r_out;
    logic            r_out_valid;

    assign w_bundle = {in_pc, w_op, w_y_sel, w_write, w_rs1, w_rs2, w_rd,
                       w_immed, w_read_mmu, w_write_mmu, w_byte_sel, w_illegal};
    assign {out_pc, op, y_sel, write, addr_a, addr_b, addr_d, immed,
            read_mmu, write_mmu, byte_sel_mmu, illegal} = r_out;
    assign out_valid = r_out_valid;

`ifdef DECODE_SKID_EN
    logic [c_BW-1:0] r_skid;
    logic            r_skid_full;

    assign in_ready = !r_skid_full && !w_hazard && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_skid      <= '0;
            r_skid_full <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            // Skid entry is older than anything on the input, so it goes first.
            if (r_skid_full) begin
                r_out       <= r_skid;
                r_out_valid <= 1'b1;
                r_skid_full <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_bundle;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid      <= w_bundle;
            r_skid_full <= 1'b1;
        end
    end
`else
    assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out       <= w_bundle;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage; directed vectors plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [13:0] op;
        logic        y_sel;
        logic        write;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  d;
        logic [31:0] imm;
        logic        rd_m;
        logic        wr_m;
        logic        bs;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic [31:0] in_pc;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [13:0] op;
    logic        y_sel;
    logic        write;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [4:0]  addr_d;
    logic [31:0] immed;
    logic        read_mmu;
    logic        write_mmu;
    logic        byte_sel_mmu;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;
    bundle_t q[$];
    logic [31:0] pc_ctr = 32'h1000;

    decode_stage #(.XLEN(32), .PC_W(32), .OP_W(14)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .op(op), .y_sel(y_sel), .write(write),
        .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d), .immed(immed),
        .read_mmu(read_mmu), .write_mmu(write_mmu),
        .byte_sel_mmu(byte_sel_mmu), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bundle_t observed();
        return {out_pc, op, y_sel, write, addr_a, addr_b, addr_d, immed,
                read_mmu, write_mmu, byte_sel_mmu, illegal};
    endfunction

    function automatic bundle_t model_decode(input logic [31:0] ir, input logic [31:0] pc);
        bundle_t b;
        int s;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit rd_nz;
        s     = int'(ir);
        opc   = ir[6:0];
        f3    = ir[14:12];
        f7    = ir[31:25];
        rd_nz = (ir[11:7] != 0);
        b     = '0;
        b.pc  = pc;
        b.a   = ir[19:15];
        b.b   = ir[24:20];
        b.d   = ir[11:7];
        b.op  = {4'b0000, opc, f3};
        b.ill = 1'b1;
        case (opc)
            7'b0110011: begin
                b.op = {opc, f7};
                if (f3 == 0 && (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01)) begin
                    b.ill = 0; b.y_sel = 1; b.write = rd_nz;
                end
            end
            7'b0000011: if (f3 == 0 || f3 == 2) begin
                b.ill = 0; b.imm = s >>> 20; b.rd_m = 1; b.bs = (f3 == 0); b.write = rd_nz;
            end
            7'b0010011: if (f3 == 0) begin
                b.ill = 0; b.imm = s >>> 20; b.write = rd_nz;
            end
            7'b0100011: if (f3 == 0 || f3 == 2) begin
                b.ill = 0; b.wr_m = 1; b.bs = (f3 == 0);
                b.imm = ((s >>> 25) << 5) | int'(ir[11:7]);
            end
            7'b1100011: if (f3 == 0) begin
                b.ill = 0; b.y_sel = 1;
                b.imm = ((s >>> 31) << 12) | (int'(ir[7]) << 11) |
                        (int'(ir[30:25]) << 5) | (int'(ir[11:8]) << 1);
            end
            7'b1101111: begin
                b.ill = 0; b.write = rd_nz;
                b.imm = ((s >>> 31) << 20) | (int'(ir[19:12]) << 12) |
                        (int'(ir[20]) << 11) | (int'(ir[30:21]) << 1);
            end
            default: ;
        endcase
        return b;
    endfunction

    function automatic bit model_hazard();
        bit rs1_used, rs2_used;
        logic [6:0] opc;
        opc      = in_ir[6:0];
        rs1_used = (opc != 7'b1101111);
        rs2_used = (opc == 7'b0110011) || (opc == 7'b0100011) || (opc == 7'b1100011);
        return in_valid && ex_load_valid && ex_load_rd != 0 &&
               ((rs1_used && in_ir[19:15] == ex_load_rd) ||
                (rs2_used && in_ir[24:20] == ex_load_rd));
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        int k;
        ir = $urandom;
        k  = $urandom_range(0, 7);
        case (k)
            0: begin
                ir[6:0] = 7'b0110011; ir[14:12] = 3'b000;
                case ($urandom_range(0, 2))
                    0: ir[31:25] = 7'h00;
                    1: ir[31:25] = 7'h20;
                    default: ir[31:25] = 7'h01;
                endcase
            end
            1: begin ir[6:0] = 7'b0000011; ir[14:12] = $urandom_range(0, 1) ? 3'b010 : 3'b000; end
            2: begin ir[6:0] = 7'b0010011; ir[14:12] = 3'b000; end
            3: begin ir[6:0] = 7'b0100011; ir[14:12] = $urandom_range(0, 1) ? 3'b010 : 3'b000; end
            4: begin ir[6:0] = 7'b1100011; ir[14:12] = 3'b000; end
            5: ir[6:0] = 7'b1101111;
            6: ;
            default: ir[6:0] = $urandom_range(0, 1) ? 7'b0110011 : 7'b0000011;
        endcase
        if (k != 6) begin
            ir[11:7]  = 5'($urandom_range(0, 3));
            ir[19:15] = 5'($urandom_range(0, 3));
            ir[24:20] = 5'($urandom_range(0, 3));
        end
        return ir;
    endfunction

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic step(output bit acc);
        bit pred_ready;
        bundle_t exp_b;
        #3;
`ifdef DECODE_SKID_EN
        pred_ready = !model_hazard() && !flush && (q.size() < 2);
`else
        pred_ready = !model_hazard() && !flush && (q.size() == 0 || out_ready);
`endif
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) check("bundle", observed(), q[0]);
        check("in_ready", in_ready, pred_ready);
        exp_b = model_decode(in_ir, in_pc);
        acc   = in_valid && pred_ready;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(exp_b);
        end
        #1;
    endtask

    task automatic issue(input logic [31:0] ir);
        bit acc;
        in_valid = 1; in_ir = ir; in_pc = pc_ctr; out_ready = 1;
        flush = 0; ex_load_valid = 0;
        pc_ctr += 4;
        step(acc);
        in_valid = 0;
    endtask

    initial begin
        bit acc;
        logic [31:0] stream [4];
        int idx;
        rst = 1; flush = 0; in_valid = 0; in_ir = '0; in_pc = '0;
        ex_load_valid = 0; ex_load_rd = '0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_bundle", observed(), '0);
        rst = 0;

        issue(32'h002081B3);
        check("add_valid", out_valid, 1);
        check("add_op", op, 14'h1980);
        check("add_y_sel", y_sel, 1);
        check("add_write", write, 1);
        check("add_rd", addr_d, 3);
        check("add_immed", immed, 0);

        issue(32'hFFC12083);
        check("ldw_immed", immed, 32'hFFFFFFFC);
        check("ldw_read", read_mmu, 1);
        check("ldw_bsel", byte_sel_mmu, 0);
        check("ldw_write", write, 1);

        issue(32'h00A10023);
        check("stb_wmmu", write_mmu, 1);
        check("stb_bsel", byte_sel_mmu, 1);
        check("stb_write", write, 0);

        issue(32'h800000EF);
        check("j_immed", immed, 32'hFFF00000);
        check("j_write", write, 1);
        issue(32'h8000006F);
        check("j_x0_immed", immed, 32'hFFF00000);

        issue(32'hFE000EE3);
        check("beq_immed", immed, 32'hFFFFFFFC);
        check("beq_y_sel", y_sel, 1);

        issue(32'hFFFFFFFF);
        check("ill_valid", out_valid, 1);
        check("ill_flag", illegal, 1);
        check("ill_flags", {write, read_mmu, write_mmu, byte_sel_mmu}, 4'b0000);
        check("ill_immed", immed, 0);

        issue(32'h00208033);
        check("add_x0_write", write, 0);
        check("add_x0_illegal", illegal, 0);

        // Load-use interlock and its rd=x0 exemption
        in_valid = 1; in_ir = 32'h002081B3; in_pc = pc_ctr;
        ex_load_valid = 1; ex_load_rd = 5'd1; out_ready = 1;
        #1;
        check("haz_in_ready", in_ready, 0);
        step(acc);
        check("haz_bubble", out_valid, 0);
        ex_load_rd = 5'd0;
        #1;
        check("nohaz_in_ready", in_ready, 1);
        step(acc);
        check("nohaz_valid", out_valid, 1);
        in_valid = 0; ex_load_valid = 0;
        step(acc);

        // Four-instruction stream with a 2-cycle stall and a mid-stream flush
        stream[0] = 32'h00100093; stream[1] = 32'h00208133;
        stream[2] = 32'h00A10023; stream[3] = 32'h40110233;
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            in_valid  = (idx < 4);
            in_ir     = stream[idx % 4];
            in_pc     = 32'h2000 + 32'(idx * 4);
            out_ready = !(c == 1 || c == 2);
            flush     = (c == 4);
            step(acc);
            if (acc) idx++;
            if (c == 4) check("flush_next_valid", out_valid, 0);
        end
        flush = 0;

        // Asynchronous reset while a bundle is held
        in_valid = 1; in_ir = 32'h00100093; in_pc = 32'h3000; out_ready = 0;
        step(acc);
        in_valid = 0;
        #1 rst = 1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_bundle", observed(), '0);
        rst = 0;
        q.delete();

        for (int i = 0; i < 600; i++) begin
            in_valid      = ($urandom_range(0, 9) < 8);
            in_ir         = rand_ir();
            in_pc         = $urandom;
            out_ready     = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 19) == 0);
            ex_load_valid = ($urandom_range(0, 9) < 3);
            ex_load_rd    = 5'($urandom_range(0, 3));
            step(acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
